// File: rtl/ptt_pkg.sv
// Shared types and helpers for the programmable truth-table gate.
//   cfg_state_t : configuration loader states
//   tt_lookup   : row lookup on a left-aligned truth table
package ptt_pkg;

  localparam int unsigned MAX_N_IN = 6;
  localparam int unsigned MAX_TW   = 1 << MAX_N_IN;

  typedef enum logic [0:0] {
    C_IDLE  = 1'b0,
    C_SHIFT = 1'b1
  } cfg_state_t;

  // The table arrives left-aligned (row 0 at the MSB), so bit TW-1-row of the
  // original table always sits at MAX_TW-1-row, which is simply ~row.
  function automatic logic tt_lookup(input logic [MAX_TW-1:0]   tt,
                                     input logic [MAX_N_IN-1:0] row);
    return tt[~row];
  endfunction

endpackage

// File: rtl/ptt_out_fifo.sv
// Small 1-bit result FIFO built as a shift register so the head is always a flop.
//   clk, rst   : clock, asynchronous active-high reset
//   push/push_bit : write request and data (ignored when full without a pop)
//   pop        : read request (ignored when empty)
//   pop_bit    : head entry
//   full/empty : registered occupancy flags
//   count      : number of stored entries
module ptt_out_fifo #(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     push_bit,
  input  logic                     pop,
  output logic                     pop_bit,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DEPTH-1:0] data_q, data_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic [CW-1:0]    wr_idx;
  logic             pop_ok;
  logic             push_ok;

  assign pop_ok  = pop & ~empty_q;
  // A pop in the same cycle frees the slot, so a full buffer can still accept.
  assign push_ok = push & (~full_q | pop_ok);
  assign wr_idx  = count_q - CW'(pop_ok);

  // Next-state: shift out on pop, write behind the last valid entry on push.
  always_comb begin
    data_d  = data_q;
    count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    if (pop_ok) begin
      data_d = data_q >> 1;
    end
    if (push_ok) begin
      data_d[AW'(wr_idx)] = push_bit;
    end
    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      data_q  <= data_d;
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  assign pop_bit = data_q[0];
  assign full    = full_q;
  assign empty   = empty_q;
  assign count   = count_q;

endmodule

// File: rtl/programmable_truth_table.sv
// Runtime-programmable N-input Boolean gate evaluated on a valid/ready stream.
// The truth table is loaded bit-serially into a shadow register and committed
// atomically on the final bit of a correctly sized load.
//   clk, reset                    : clock, asynchronous active-high reset
//   cfg_valid/cfg_bit/cfg_last    : serial table load, row 0 first
//   cfg_ready                     : always ready
//   cfg_err                       : sticky, last load had the wrong bit count
//   in_valid/in_ready/in_vec      : input vector stream, in_vec is the row index
//   out_valid/out_ready/out_bit   : result stream (buffered, FIFO order)
//   tt_active                     : committed table, MSB = row 0
module programmable_truth_table
  import ptt_pkg::*;
#(
  parameter int unsigned             N_IN      = 3,
  parameter logic [(1<<N_IN)-1:0]    RESET_TT  = 8'h43,
  parameter int unsigned             OUT_DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cfg_valid,
  input  logic                   cfg_bit,
  input  logic                   cfg_last,
  output logic                   cfg_ready,
  output logic                   cfg_err,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N_IN-1:0]        in_vec,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_bit,
  output logic [(1<<N_IN)-1:0]   tt_active
);

  localparam int unsigned TW    = 1 << N_IN;
  localparam int unsigned IW    = $clog2(TW);
  localparam int unsigned CNT_W = IW + 1;
  localparam int unsigned FCW   = $clog2(OUT_DEPTH) + 1;

  cfg_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TW-1:0]    shadow_q, shadow_d;
  logic [TW-1:0]    tt_active_q, tt_active_d;
  logic             cfg_err_q, cfg_err_d;
  logic             drop_q, drop_d;

  logic             fifo_full;
  logic             fifo_empty;
  logic [FCW-1:0]   fifo_count;
  logic             out_pop;
  logic             in_push;
  logic             lookup_bit;
  logic [MAX_TW-1:0] tt_aligned;

  // Configuration loader: next-state, shadow fill and commit.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shadow_d    = shadow_q;
    tt_active_d = tt_active_q;
    cfg_err_d   = cfg_err_q;
    drop_d      = drop_q;
    unique case (state_q)
      C_IDLE: begin
        if (cfg_valid) begin
          if (drop_q) begin
            // Swallow the tail of an overlong load up to its cfg_last.
            if (cfg_last) begin
              drop_d = 1'b0;
            end
          end else begin
            shadow_d[TW-1] = cfg_bit;
            if (cfg_last) begin
              // N_IN >= 1 means TW >= 2, so a single-bit load is always short.
              cfg_err_d = 1'b1;
            end else begin
              cnt_d   = CNT_W'(1);
              state_d = C_SHIFT;
            end
          end
        end
      end
      C_SHIFT: begin
        if (cfg_valid) begin
          if (cnt_q == CNT_W'(TW)) begin
            // Bit TW+1: abandon the load; drop the rest unless this bit ends it.
            cfg_err_d = 1'b1;
            cnt_d     = '0;
            state_d   = C_IDLE;
            drop_d    = ~cfg_last;
          end else begin
            shadow_d[IW'(CNT_W'(TW - 1) - cnt_q)] = cfg_bit;
            cnt_d = cnt_q + CNT_W'(1);
            if (cfg_last) begin
              cnt_d   = '0;
              state_d = C_IDLE;
              if (cnt_q == CNT_W'(TW - 1)) begin
                tt_active_d = shadow_d;
                cfg_err_d   = 1'b0;
              end else begin
                cfg_err_d = 1'b1;
              end
            end
          end
        end
      end
      default: begin
        state_d = C_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= C_IDLE;
      cnt_q       <= '0;
      shadow_q    <= '0;
      tt_active_q <= RESET_TT;
      cfg_err_q   <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shadow_q    <= shadow_d;
      tt_active_q <= tt_active_d;
      cfg_err_q   <= cfg_err_d;
      drop_q      <= drop_d;
    end
  end

  // Lookup always uses the table committed before this edge.
  assign tt_aligned = MAX_TW'(tt_active_q) << (MAX_TW - TW);
  assign lookup_bit = tt_lookup(tt_aligned, MAX_N_IN'(in_vec));

  assign out_pop  = out_valid & out_ready;
  assign in_ready = ~fifo_full | out_pop;
  assign in_push  = in_valid & in_ready;

  ptt_out_fifo #(
    .DEPTH (OUT_DEPTH)
  ) u_out_fifo (
    .clk      (clk),
    .rst      (reset),
    .push     (in_push),
    .push_bit (lookup_bit),
    .pop      (out_pop),
    .pop_bit  (out_bit),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  // Occupancy can never exceed the buffer depth.
  a_count_bound: assert property (@(posedge clk) disable iff (reset)
                                  fifo_count <= FCW'(OUT_DEPTH));

  assign out_valid = ~fifo_empty;
  assign cfg_ready = 1'b1;
  assign cfg_err   = cfg_err_q;
  assign tt_active = tt_active_q;

endmodule
